// File: rtl/sd_pkg.sv
// Shared defaults and the FIFO entry type for the event logger.
package sd_pkg;

  localparam int SD_TS_W  = 8;
  localparam int SD_DEPTH = 4;
  localparam int SD_CNT_W = 16;

  typedef struct packed {
    logic [SD_TS_W-1:0] ts;
  } sd_evt_t;

endpackage

// File: rtl/sd_evt_fifo.sv
// Small register-based event FIFO; occupancy tracked by a counter so full/empty never rely on pointer equality.
module sd_evt_fifo
  import sd_pkg::*;
#(
  parameter int  DEPTH = SD_DEPTH,
  parameter type T     = sd_evt_t,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        clr,
  input  logic        push,
  input  logic        pop,
  input  T            wdata,
  output T            rdata,
  output logic [AW:0] level,
  output logic        full,
  output logic        empty
);

  T              mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  // A push into a full FIFO is only legal when the head leaves on the same edge.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);
  assign rdata = mem[rptr];

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + 1'b1;
      end
      if (do_pop) rptr <= rptr + 1'b1;
      if (do_push && !do_pop) level <= level + 1'b1;
      else if (do_pop && !do_push) level <= level - 1'b1;
    end
  end

endmodule

// File: rtl/sd_event_logger.sv
// Timestamps each detector hit, queues it for a ready/valid consumer, and keeps hit and drop statistics.
module sd_event_logger
  import sd_pkg::*;
#(
  parameter int TS_W  = SD_TS_W,
  parameter int DEPTH = SD_DEPTH,
  parameter int CNT_W = SD_CNT_W
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic                     Y,
  input  logic                     Clr,
  output logic                     Rd_Valid,
  input  logic                     Rd_Ready,
  output logic [TS_W-1:0]          Rd_Ts,
  output logic [$clog2(DEPTH):0]   Level,
  output logic [CNT_W-1:0]         Match_Cnt,
  output logic                     Overflow
);

  typedef struct packed {
    logic [TS_W-1:0] ts;
  } evt_t;

  logic [TS_W-1:0] ts;
  evt_t            wr_evt;
  evt_t            rd_evt;
  logic            fifo_full;
  logic            fifo_empty;
  logic            pop;
  logic            drop;

  assign Rd_Valid = !fifo_empty;
  assign pop      = Rd_Valid && Rd_Ready;
  assign drop     = Y && fifo_full && !pop;
  assign wr_evt   = '{ts: ts};
  assign Rd_Ts    = rd_evt.ts;

  sd_evt_fifo #(
    .DEPTH (DEPTH),
    .T     (evt_t)
  ) u_fifo (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .clr   (Clr),
    .push  (Y),
    .pop   (pop),
    .wdata (wr_evt),
    .rdata (rd_evt),
    .level (Level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) ts <= '0;
    else if (Clr) ts <= '0;
    else ts <= ts + 1'b1;
  end

  // Counts every hit, including dropped ones, and parks at all-ones instead of wrapping.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) Match_Cnt <= '0;
    else if (Clr) Match_Cnt <= '0;
    else if (Y && (Match_Cnt != '1)) Match_Cnt <= Match_Cnt + 1'b1;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) Overflow <= 1'b0;
    else if (Clr) Overflow <= 1'b0;
    else if (drop) Overflow <= 1'b1;
  end

endmodule

// File: tb/tb_sd_event_logger.sv
// Self-checking bench for sd_event_logger: directed scenarios plus random traffic against a queue-based model.
module tb_sd_event_logger;

  localparam int TS_W  = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = 5;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             Clk;
  logic             Rst_n;
  logic             Y;
  logic             Clr;
  logic             Rd_Valid;
  logic             Rd_Ready;
  logic [TS_W-1:0]  Rd_Ts;
  logic [LW-1:0]    Level;
  logic [CNT_W-1:0] Match_Cnt;
  logic             Overflow;

  int checks = 0;
  int failures = 0;

  int model_q[$];
  int model_ts;
  int model_cnt;
  bit model_ovf;

  sd_event_logger #(
    .TS_W  (TS_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .Y         (Y),
    .Clr       (Clr),
    .Rd_Valid  (Rd_Valid),
    .Rd_Ready  (Rd_Ready),
    .Rd_Ts     (Rd_Ts),
    .Level     (Level),
    .Match_Cnt (Match_Cnt),
    .Overflow  (Overflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic void model_reset();
    model_q.delete();
    model_ts  = 0;
    model_cnt = 0;
    model_ovf = 0;
  endfunction

  // One clock edge of the logger's intended behaviour, pop considered before the push.
  function automatic void model_edge(bit y, bit rdy, bit clr);
    if (clr) begin
      model_reset();
      return;
    end
    if (rdy && model_q.size() > 0) void'(model_q.pop_front());
    if (y) begin
      if (model_cnt < (1 << CNT_W) - 1) model_cnt++;
      if (model_q.size() < DEPTH) model_q.push_back(model_ts);
      else model_ovf = 1;
    end
    model_ts = (model_ts + 1) % (1 << TS_W);
  endfunction

  task automatic apply_stimulus(input bit y, input bit rdy, input bit clr);
    Y = y;
    Rd_Ready = rdy;
    Clr = clr;
    @(posedge Clk);
    model_edge(y, rdy, clr);
    @(negedge Clk);
  endtask

  task automatic apply_reset();
    Y = 1'b0;
    Rd_Ready = 1'b0;
    Clr = 1'b0;
    Rst_n = 1'b0;
    #1;
    Rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    Y = 1'b1;
    Rd_Ready = 1'b1;
    Clr = 1'b0;
    repeat (2) @(negedge Clk);
    model_reset();
    checks++; if (Rd_Valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b expected 0", Rd_Valid); end
    checks++; if (Level !== LW'(0)) begin failures++; $display("FAIL reset_level: got %0d expected 0", Level); end
    checks++; if (Match_Cnt !== CNT_W'(0)) begin failures++; $display("FAIL reset_cnt: got %0d expected 0", Match_Cnt); end
    checks++; if (Overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %0b expected 0", Overflow); end
    checks++; if (Rd_Ts !== TS_W'(0)) begin failures++; $display("FAIL reset_ts: got %0d expected 0", Rd_Ts); end
    Y = 1'b0;
    Rst_n = 1'b1;
    apply_stimulus(0, 0, 0);
    checks++; if (Level !== LW'(0)) begin failures++; $display("FAIL reset_no_push: got %0d expected 0", Level); end
  endtask

  task automatic test_sequence();
    bit [1:0] hist = 2'b00;
    bit       xs [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    bit       y;
    int       pulse_idx = -1;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      y = hist[1] && hist[0] && !xs[i];
      if (y) pulse_idx = i;
      apply_stimulus(y, 0, 0);
      hist = {hist[0], xs[i]};
    end
    checks++; if (Level !== LW'(1)) begin failures++; $display("FAIL seq_level: got %0d expected 1", Level); end
    checks++; if (Rd_Valid !== 1'b1) begin failures++; $display("FAIL seq_valid: got %0b expected 1", Rd_Valid); end
    checks++; if (Rd_Ts !== TS_W'(pulse_idx)) begin failures++; $display("FAIL seq_ts: got %0d expected %0d", Rd_Ts, pulse_idx); end
    checks++; if (Match_Cnt !== CNT_W'(1)) begin failures++; $display("FAIL seq_cnt: got %0d expected 1", Match_Cnt); end
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 0; i < 10; i++) apply_stimulus(0, 0, 0);
    for (int i = 0; i < 6; i++) apply_stimulus(1, 0, 0);
    checks++; if (Level !== LW'(4)) begin failures++; $display("FAIL ovf_level: got %0d expected 4", Level); end
    checks++; if (Overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag: got %0b expected 1", Overflow); end
    checks++; if (Match_Cnt !== CNT_W'(6)) begin failures++; $display("FAIL ovf_cnt: got %0d expected 6", Match_Cnt); end
    checks++; if (Rd_Ts !== TS_W'(10)) begin failures++; $display("FAIL ovf_head: got %0d expected 10", Rd_Ts); end
    apply_stimulus(0, 0, 0);
    checks++; if (Rd_Ts !== TS_W'(10)) begin failures++; $display("FAIL ovf_hold: got %0d expected 10", Rd_Ts); end
  endtask

  task automatic test_full_push_pop();
    int app_ts = model_ts;
    int exp_ts [4];
    apply_stimulus(1, 1, 0);
    checks++; if (Level !== LW'(4)) begin failures++; $display("FAIL fpp_level: got %0d expected 4", Level); end
    checks++; if (Overflow !== 1'b1) begin failures++; $display("FAIL fpp_ovf: got %0b expected 1", Overflow); end
    checks++; if (Match_Cnt !== CNT_W'(7)) begin failures++; $display("FAIL fpp_cnt: got %0d expected 7", Match_Cnt); end
    exp_ts = '{11, 12, 13, app_ts};
    for (int i = 0; i < 4; i++) begin
      checks++; if (Rd_Ts !== TS_W'(exp_ts[i])) begin failures++; $display("FAIL fpp_drain%0d: got %0d expected %0d", i, Rd_Ts, exp_ts[i]); end
      apply_stimulus(0, 1, 0);
    end
    checks++; if (Rd_Valid !== 1'b0) begin failures++; $display("FAIL fpp_empty: got %0b expected 0", Rd_Valid); end
  endtask

  task automatic test_wrap();
    int exp_ts [3] = '{254, 255, 0};
    apply_reset();
    for (int i = 0; i < 300 && model_ts != 254; i++) apply_stimulus(0, 0, 0);
    for (int i = 0; i < 3; i++) apply_stimulus(1, 0, 0);
    checks++; if (Level !== LW'(3)) begin failures++; $display("FAIL wrap_level: got %0d expected 3", Level); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (Rd_Ts !== TS_W'(exp_ts[i])) begin failures++; $display("FAIL wrap_ts%0d: got %0d expected %0d", i, Rd_Ts, exp_ts[i]); end
      apply_stimulus(0, 1, 0);
    end
  endtask

  task automatic test_clear();
    apply_reset();
    for (int i = 0; i < 5; i++) apply_stimulus(1, 0, 0);
    apply_stimulus(0, 1, 0);
    checks++; if (Level !== LW'(3)) begin failures++; $display("FAIL clr_pre_level: got %0d expected 3", Level); end
    checks++; if (Overflow !== 1'b1) begin failures++; $display("FAIL clr_pre_ovf: got %0b expected 1", Overflow); end
    apply_stimulus(1, 0, 1);
    checks++; if (Level !== LW'(0)) begin failures++; $display("FAIL clr_level: got %0d expected 0", Level); end
    checks++; if (Rd_Valid !== 1'b0) begin failures++; $display("FAIL clr_valid: got %0b expected 0", Rd_Valid); end
    checks++; if (Match_Cnt !== CNT_W'(0)) begin failures++; $display("FAIL clr_cnt: got %0d expected 0", Match_Cnt); end
    checks++; if (Overflow !== 1'b0) begin failures++; $display("FAIL clr_ovf: got %0b expected 0", Overflow); end
    apply_stimulus(1, 0, 0);
    checks++; if (Rd_Ts !== TS_W'(0)) begin failures++; $display("FAIL clr_ts_restart: got %0d expected 0", Rd_Ts); end
    checks++; if (Match_Cnt !== CNT_W'(1)) begin failures++; $display("FAIL clr_cnt_restart: got %0d expected 1", Match_Cnt); end
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int i = 0; i < 40; i++) apply_stimulus(1, 1, 0);
    checks++; if (Match_Cnt !== CNT_W'(31)) begin failures++; $display("FAIL sat_cnt: got %0d expected 31", Match_Cnt); end
    checks++; if (Overflow !== 1'b0) begin failures++; $display("FAIL sat_ovf: got %0b expected 0", Overflow); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    apply_stimulus(1, 0, 0);
    apply_stimulus(1, 0, 0);
    checks++; if (Level !== LW'(2)) begin failures++; $display("FAIL ares_pre_level: got %0d expected 2", Level); end
    #2;
    Rst_n = 1'b0;
    #1;
    checks++; if (Rd_Valid !== 1'b0) begin failures++; $display("FAIL ares_valid: got %0b expected 0", Rd_Valid); end
    checks++; if (Level !== LW'(0)) begin failures++; $display("FAIL ares_level: got %0d expected 0", Level); end
    checks++; if (Match_Cnt !== CNT_W'(0)) begin failures++; $display("FAIL ares_cnt: got %0d expected 0", Match_Cnt); end
    checks++; if (Overflow !== 1'b0) begin failures++; $display("FAIL ares_ovf: got %0b expected 0", Overflow); end
    checks++; if (Rd_Ts !== TS_W'(0)) begin failures++; $display("FAIL ares_ts: got %0d expected 0", Rd_Ts); end
    #1;
    Y = 1'b0;
    Rst_n = 1'b1;
    model_reset();
    apply_stimulus(0, 0, 0);
    checks++; if (Level !== LW'(0)) begin failures++; $display("FAIL ares_no_push: got %0d expected 0", Level); end
    apply_stimulus(1, 0, 0);
    checks++; if (Rd_Ts !== TS_W'(1)) begin failures++; $display("FAIL ares_first_ts: got %0d expected 1", Rd_Ts); end
  endtask

  task automatic test_random();
    bit y, rdy, clr;
    int rdy_pct;
    apply_reset();
    for (int i = 0; i < 500; i++) begin
      rdy_pct = ((i / 100) % 2 == 0) ? 80 : 20;
      y   = ($urandom_range(0, 99) < 55);
      rdy = ($urandom_range(0, 99) < rdy_pct);
      clr = ($urandom_range(0, 99) == 0);
      apply_stimulus(y, rdy, clr);
      checks++; if (Level !== LW'(model_q.size())) begin failures++; $display("FAIL rnd_level@%0d: got %0d expected %0d", i, Level, model_q.size()); end
      checks++; if (Rd_Valid !== (model_q.size() > 0)) begin failures++; $display("FAIL rnd_valid@%0d: got %0b expected %0b", i, Rd_Valid, model_q.size() > 0); end
      checks++; if (Match_Cnt !== CNT_W'(model_cnt)) begin failures++; $display("FAIL rnd_cnt@%0d: got %0d expected %0d", i, Match_Cnt, model_cnt); end
      checks++; if (Overflow !== model_ovf) begin failures++; $display("FAIL rnd_ovf@%0d: got %0b expected %0b", i, Overflow, model_ovf); end
      if (model_q.size() > 0) begin
        checks++; if (Rd_Ts !== TS_W'(model_q[0])) begin failures++; $display("FAIL rnd_ts@%0d: got %0d expected %0d", i, Rd_Ts, model_q[0]); end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    Rst_n = 1'b0;
    Y = 1'b0;
    Clr = 1'b0;
    Rd_Ready = 1'b0;
    @(negedge Clk);
    test_reset();
    test_sequence();
    test_overflow();
    test_full_push_pop();
    test_wrap();
    test_clear();
    test_saturation();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sd_event_logger.md
SD_EVENT_LOGGER -- requirements
Module: sd_event_logger

Interface
REQ-001 Parameter TS_W, default 8, timestamp width in bits.
REQ-002 Parameter DEPTH, default 4, event FIFO depth in entries, power of two, at least 2.
REQ-003 Parameter CNT_W, default 16, width of the match counter.
REQ-004 Clk  input  1  single clock; all state updates on the rising edge.
REQ-005 Rst_n  input  1  asynchronous, active-low reset.
REQ-006 Y  input  1  detection output of the upstream sequence detector; each cycle sampled high is one event.
REQ-007 Clr  input  1  synchronous clear of all logger state.
REQ-008 Rd_Valid  output  1  head FIFO entry is available.
REQ-009 Rd_Ready  input  1  consumer accepts the head entry.
REQ-010 Rd_Ts  output  TS_W  timestamp of the head entry; valid only while Rd_Valid is high.
REQ-011 Level  output  clog2(DEPTH)+1  current FIFO occupancy.
REQ-012 Match_Cnt  output  CNT_W  total number of events seen since reset or clear.
REQ-013 Overflow  output  1  sticky flag; at least one event was dropped.

Function
REQ-014 A free-running TS_W-bit timestamp counter shall increment every cycle and wrap from 2^TS_W-1 to 0.
REQ-015 Any cycle with Y=1 shall push the current timestamp value (the value before that edge's increment) into the FIFO.
REQ-016 The push latency shall be 1 cycle: an event sampled at edge t gives Rd_Valid=1 and Rd_Ts equal to that timestamp after edge t; there is no combinational bypass from Y.
REQ-017 A pop shall occur on any edge where Rd_Valid=1 and Rd_Ready=1.
REQ-018 Rd_Ready while Rd_Valid=0 shall have no effect.
REQ-019 While Rd_Valid=1 and Rd_Ready=0, Rd_Ts shall be held stable.
REQ-020 Push and pop in the same cycle shall both take effect, with Level unchanged, including when the FIFO is full.
REQ-021 If the FIFO is full (Level=DEPTH), Y=1 and no pop occurs in the same cycle, the event shall be dropped, Overflow shall set, and FIFO contents shall be unchanged.
REQ-022 Match_Cnt shall increment on every event, including dropped events, and shall saturate at 2^CNT_W-1 with no wrap.
REQ-023 Read and write pointers shall wrap modulo DEPTH; Level shall be derived from an occupancy counter, never from pointer comparison alone.
REQ-024 When Clr=1 on an edge, all state shall return to reset values; Clr shall have priority over a simultaneous Y or pop, and that event shall be lost and not counted.
REQ-025 Overflow shall clear only on reset or Clr.

Reset
REQ-026 Rst_n=0 shall immediately and asynchronously force: timestamp=0, pointers=0, Level=0, Rd_Valid=0, Match_Cnt=0, Overflow=0.
REQ-027 Rd_Ts shall be don't-care while Rd_Valid=0; the bench shall check it for 0 only directly after reset.
REQ-028 Reset deassertion mid-stream shall produce no spurious push: the first push shall require Y=1 sampled on an edge after Rst_n has risen.

Structure
REQ-029 Package sd_pkg shall hold the default TS_W, DEPTH and CNT_W constants and the sd_evt_t typedef (timestamp field).
REQ-030 The FIFO shall be a separate sub-module sd_evt_fifo with ports push, pop, wdata, rdata, level, full and empty.
REQ-031 The timestamp counter, match counter, overflow logic and handshake shall live in the top module sd_event_logger.

Verification
REQ-032 Reset, then drive the X stream 1,1,0 into the sequence detector with Y connected -> exactly one entry; Rd_Ts equals the cycle index of the Y pulse; Match_Cnt=1.
REQ-033 Hold Y=1 for 6 cycles from timestamp 10 with Rd_Ready=0 -> Level=4; entries are 10,11,12,13; Overflow=1; Match_Cnt=6.
REQ-034 With the FIFO full, assert Y=1 and Rd_Ready=1 for one cycle -> head popped, new timestamp appended, Level stays 4, Overflow unchanged.
REQ-035 Run until the timestamp reaches 254, then send events at 254, 255 and 0 -> Rd_Ts reads 254, 255, 0 in order.
REQ-036 Assert Clr together with Y=1 while Level=3 -> next cycle Level=0, Rd_Valid=0, Match_Cnt=0, Overflow=0.
REQ-037 Assert Rst_n=0 asynchronously between edges while Level=2 -> all outputs reach reset values before the next edge.
